// File: rtl/pulse_scheduler.sv
// pulse_scheduler
//   Clocked replacement for the delay-based pulse generators. Three
//   asynchronous triggers (short/medium/long pulse classes) each queue one
//   request on a rising edge; a round-robin scheduler emits one fixed-width
//   pulse per request on a shared line, with a guaranteed low gap between
//   pulses.
// Ports
//   clk          system clock, the only clock
//   rst_n        synchronous active-low reset
//   trig[2:0]    asynchronous requests, rising-edge sensitive, bit i = requester i
//   enable       1 = grants allowed, 0 = hold queued requests
//   clr_overrun  one-cycle strobe, clears all overrun bits
//   pulse        shared pulse output (registered)
//   pulse_src    requester owning the current/last pulse (registered)
//   busy         high while a pulse or its trailing gap is in progress
//   pending      per-requester queued-request flags
//   overrun      sticky per-requester "request dropped" flags

// Per-requester input capture: 2-flop synchronizer, third flop for edge
// detect, and a registered rise strobe. A trigger rising before edge 0
// shows up on rise after edge 2.
module pulse_trig_capture (
   input  logic clk,
   input  logic rst_n,
   input  logic trig,
   output logic rise
);
   logic [2:0] sync;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync <= '0;
         rise <= 1'b0;
      end else begin
         sync <= {sync[1:0], trig};
         rise <= sync[1] & ~sync[2];
      end
   end
endmodule

module pulse_scheduler #(
   parameter int unsigned WIDTH0 = 5,
   parameter int unsigned WIDTH1 = 25,
   parameter int unsigned WIDTH2 = 50,
   parameter int unsigned GAP    = 5,
   parameter int unsigned CNT_W  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] trig,
   input  logic       enable,
   input  logic       clr_overrun,
   output logic       pulse,
   output logic [1:0] pulse_src,
   output logic       busy,
   output logic [2:0] pending,
   output logic [2:0] overrun
);
   localparam int NUM_REQ = 3;
   localparam logic [CNT_W-1:0] GAP_LD = (GAP == 0) ? '0 : CNT_W'(GAP - 1);

   typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [1:0]         last_grant;
   logic [NUM_REQ-1:0] rise;
   logic               grant_vld;
   logic [1:0]         grant_idx;
   logic [NUM_REQ-1:0] grant_mask;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_cap
         pulse_trig_capture u_cap (
            .clk   (clk),
            .rst_n (rst_n),
            .trig  (trig[gi]),
            .rise  (rise[gi])
         );
      end
   endgenerate

   function automatic logic [1:0] next_idx(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   // Counter preload for a granted requester; a zero width still gives one cycle.
   function automatic logic [CNT_W-1:0] load_val(input logic [1:0] idx);
      int unsigned w;
      case (idx)
         2'd0:    w = WIDTH0;
         2'd1:    w = WIDTH1;
         default: w = WIDTH2;
      endcase
      if (w == 0) w = 1;
      return CNT_W'(w - 1);
   endfunction

   // Round-robin: first pending requester after last_grant, wrapping mod 3.
   always_comb begin
      logic [1:0] cand;
      logic       found;
      cand      = last_grant;
      found     = 1'b0;
      grant_idx = last_grant;
      for (int j = 0; j < NUM_REQ; j++) begin
         cand = next_idx(cand);
         if (!found && pending[cand]) begin
            found     = 1'b1;
            grant_idx = cand;
         end
      end
      grant_vld  = found && enable && (state == S_IDLE);
      grant_mask = grant_vld ? (3'b001 << grant_idx) : 3'b000;
   end

   // One-deep queue per requester. An edge coinciding with the grant of the
   // same requester re-queues it; otherwise an edge onto a full slot is lost.
   // A fresh overrun outranks a simultaneous clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending <= '0;
         overrun <= '0;
      end else begin
         pending <= rise | (pending & ~grant_mask);
         overrun <= (overrun & {NUM_REQ{~clr_overrun}}) | (rise & pending & ~grant_mask);
      end
   end

   // A grant is only taken from IDLE, so between pulses the line is low for
   // the GAP cycles plus the one IDLE cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         last_grant <= 2'd2;
         pulse_src  <= 2'd0;
         pulse      <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_vld) begin
                  state      <= S_PULSE;
                  cnt        <= load_val(grant_idx);
                  last_grant <= grant_idx;
                  pulse_src  <= grant_idx;
                  pulse      <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            S_PULSE: begin
               if (cnt == '0) begin
                  pulse <= 1'b0;
                  if (GAP == 0) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= S_GAP;
                     cnt   <= GAP_LD;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_GAP: begin
               if (cnt == '0) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state <= S_IDLE;
               pulse <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_pulse_scheduler.sv
// Bench for pulse_scheduler: one GAP=5 instance (a) and one GAP=0 instance
// (b) share all inputs. A request/time-based model predicts every output
// each cycle; directed sequences add literal expectations.
module tb_pulse_scheduler;
   logic       clk = 1'b0;
   logic       rst_n, enable, clr_overrun;
   logic [2:0] trig;
   logic       pulse_a, pulse_b, busy_a, busy_b;
   logic [1:0] src_a, src_b;
   logic [2:0] pend_a, pend_b, ovr_a, ovr_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pulse_scheduler #(.GAP(5)) dut_a (
      .clk(clk), .rst_n(rst_n), .trig(trig), .enable(enable), .clr_overrun(clr_overrun),
      .pulse(pulse_a), .pulse_src(src_a), .busy(busy_a), .pending(pend_a), .overrun(ovr_a));

   pulse_scheduler #(.GAP(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .trig(trig), .enable(enable), .clr_overrun(clr_overrun),
      .pulse(pulse_b), .pulse_src(src_b), .busy(busy_b), .pending(pend_b), .overrun(ovr_b));

   logic [1:0]       pl, bv;
   logic [1:0][1:0]  sv;
   logic [1:0][2:0]  pv, ov;
   assign pl = {pulse_b, pulse_a};
   assign bv = {busy_b, busy_a};
   assign sv = {src_b, src_a};
   assign pv = {pend_b, pend_a};
   assign ov = {ovr_b, ovr_a};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- model ----------------
   // A request exists 3 edges after the trigger was first sampled high.
   // A grant at edge n owns the line for W edges and keeps busy for W+gap.
   logic [2:0] h [1:4];
   int         now;
   logic       m_valid = 1'b0;
   logic       m_pulse [2], m_busy [2];
   logic [2:0] m_pend [2], m_ovr [2];
   logic [1:0] m_src [2];
   int         m_last [2], m_pend_end [2], m_busy_end [2];

   function automatic int wid(input int i);
      return (i == 0) ? 5 : (i == 1) ? 25 : 50;
   endfunction

   always @(posedge clk) begin
      logic [2:0] ev, gmask;
      int g;
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_pulse[k] = 0; m_busy[k] = 0; m_pend[k] = 0; m_ovr[k] = 0;
            m_src[k] = 0; m_last[k] = 2; m_pend_end[k] = 0; m_busy_end[k] = 0;
         end
         for (int i = 1; i <= 4; i++) h[i] = 3'b000;
         now = 0;
      end else begin
         now++;
         ev = h[3] & ~h[4];
         for (int k = 0; k < 2; k++) begin
            gmask = 3'b000;
            g = -1;
            if (!m_busy[k] && enable && m_pend[k] != 0) begin
               for (int j = 1; j <= 3; j++) begin
                  int idx;
                  idx = (m_last[k] + j) % 3;
                  if (g < 0 && m_pend[k][idx]) g = idx;
               end
               gmask = 3'b001 << g;
               m_last[k] = g;
               m_src[k] = 2'(g);
               m_pend_end[k] = now + wid(g);
               m_busy_end[k] = now + wid(g) + ((k == 0) ? 5 : 0);
            end
            m_ovr[k] = (clr_overrun ? 3'b000 : m_ovr[k]) | (ev & m_pend[k] & ~gmask);
            m_pend[k] = ev | (m_pend[k] & ~gmask);
            m_pulse[k] = (now < m_pend_end[k]);
            m_busy[k] = (now < m_busy_end[k]);
         end
         for (int i = 4; i > 1; i--) h[i] = h[i-1];
         h[1] = trig;
      end
      m_valid = 1'b1;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("m_pulse%0d t=%0d", k, now), pl[k], m_pulse[k]);
            chk($sformatf("m_busy%0d t=%0d", k, now), bv[k], m_busy[k]);
            chk($sformatf("m_src%0d t=%0d", k, now), sv[k], m_src[k]);
            chk($sformatf("m_pend%0d t=%0d", k, now), pv[k], m_pend[k]);
            chk($sformatf("m_ovr%0d t=%0d", k, now), ov[k], m_ovr[k]);
         end
      end
   end

   // ---------------- directed ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_pulse(input int k, input string nm);
      int n = 0;
      while (!pl[k] && n < 200) begin tick(1); n++; end
      chk({nm, " pulse seen"}, pl[k], 1);
   endtask

   task automatic run_len(input int k, input logic lvl, output int len);
      len = 0;
      while (pl[k] === lvl && len < 300) begin len++; tick(1); end
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      tick(5);
      while ((bv != 0 || pv != 0) && n < 400) begin tick(1); n++; end
      chk({nm, " idle"}, {bv, pv}, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
   endtask

   initial begin
      int w, b, rises;
      logic [1:0] lsrc;
      logic prev;
      rst_n = 1'b0; trig = 3'b000; enable = 1'b1; clr_overrun = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(1);
      chk("reset pulse", pulse_a, 0);
      chk("reset busy", busy_a, 0);
      chk("reset pending", pend_a, 0);
      chk("reset overrun", ovr_a, 0);
      chk("reset src", src_a, 0);

      // single request: latency, width, busy span
      trig = 3'b001;
      tick(3);
      chk("t1 pend after e2", pend_a, 3'b000);
      tick(1);
      chk("t1 pend after e3", pend_a, 3'b001);
      chk("t1 pulse after e3", pulse_a, 0);
      tick(1);
      chk("t1 pulse after e4", pulse_a, 1);
      chk("t1 src", src_a, 0);
      run_len(0, 1'b1, w);
      chk("t1 width", w, 5);
      b = w;
      while (busy_a && b < 200) begin b++; tick(1); end
      chk("t1 busy span", b, 10);
      trig = 3'b000;
      wait_idle("t1");

      // all three at once, from reset priority
      do_reset();
      trig = 3'b111;
      wait_pulse(0, "t2");
      chk("t2 src0", src_a, 0);
      chk("t2 pend0", pend_a, 3'b110);
      run_len(0, 1'b1, w); chk("t2 w0", w, 5);
      run_len(0, 1'b0, w); chk("t2 low0", w, 6);
      chk("t2 src1", src_a, 1);
      chk("t2 pend1", pend_a, 3'b100);
      run_len(0, 1'b1, w); chk("t2 w1", w, 25);
      run_len(0, 1'b0, w); chk("t2 low1", w, 6);
      chk("t2 src2", src_a, 2);
      chk("t2 pend2", pend_a, 3'b000);
      run_len(0, 1'b1, w); chk("t2 w2", w, 50);
      trig = 3'b000;
      wait_idle("t2");

      // GAP=0 instance: back-to-back with a single low cycle
      trig = 3'b011;
      wait_pulse(1, "t6");
      chk("t6 src0", src_b, 0);
      run_len(1, 1'b1, w); chk("t6 w0", w, 5);
      run_len(1, 1'b0, w); chk("t6 low", w, 1);
      chk("t6 src1", src_b, 1);
      run_len(1, 1'b1, w); chk("t6 w1", w, 25);
      trig = 3'b000;
      wait_idle("t6");

      // overrun during a long pulse
      trig = 3'b100;
      wait_pulse(0, "t3");
      chk("t3 src2", src_a, 2);
      trig = 3'b110; tick(3);
      trig = 3'b100; tick(3);
      trig = 3'b110; tick(5);
      chk("t3 overrun", ovr_a, 3'b010);
      trig = 3'b000;
      rises = 0; lsrc = 2'd3; prev = pulse_a;
      for (int i = 0; i < 150; i++) begin
         tick(1);
         if (pulse_a && !prev) begin rises++; lsrc = src_a; end
         prev = pulse_a;
      end
      chk("t3 src1 pulses", rises, 1);
      chk("t3 src1 owner", lsrc, 1);
      clr_overrun = 1'b1; tick(1); clr_overrun = 1'b0;
      chk("t3 cleared", ovr_a, 3'b000);

      // clear coincident with a new overrun: overrun wins
      trig = 3'b100;
      wait_pulse(0, "t3b");
      trig = 3'b110; tick(3);
      trig = 3'b100; tick(3);
      trig = 3'b110; tick(3);
      clr_overrun = 1'b1; tick(1); clr_overrun = 1'b0;
      chk("t3b overrun kept", ovr_a, 3'b010);
      trig = 3'b000;
      clr_overrun = 1'b1; tick(1); clr_overrun = 1'b0;
      wait_idle("t3b");

      // enable=0 holds the request
      enable = 1'b0;
      trig = 3'b100;
      w = 0;
      for (int i = 0; i < 100; i++) begin tick(1); if (pulse_a) w++; end
      chk("t4 held low", w, 0);
      chk("t4 pending", pend_a, 3'b100);
      enable = 1'b1;
      tick(1);
      chk("t4 pulse after enable", pulse_a, 1);
      run_len(0, 1'b1, w); chk("t4 width", w, 50);
      trig = 3'b000;
      wait_idle("t4");

      // reset in the middle of a long pulse, then normal service
      trig = 3'b100;
      wait_pulse(0, "t5");
      tick(9);
      trig = 3'b000;
      rst_n = 1'b0;
      tick(1);
      chk("t5 pulse", pulse_a, 0);
      chk("t5 pending", pend_a, 0);
      chk("t5 busy", busy_a, 0);
      rst_n = 1'b1;
      tick(2);
      trig = 3'b001;
      tick(4);
      chk("t5 pulse after e3", pulse_a, 0);
      tick(1);
      chk("t5 pulse after e4", pulse_a, 1);
      chk("t5 src", src_a, 0);
      trig = 3'b000;
      wait_idle("t5");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
